pwm_duty_meter: RTL
===================

// Module: pwm_duty_meter
// PURPOSE
//  Downstream consumer of the PWM generator stage. Measures each incoming PWM period:
//  high time and full period in clk cycles (optionally duty in percent).
//  Reports a result every period. Flags a stuck-at line (0 %/100 % duty or dead source).
// PARAMETERS
//  CW  16  width of high/period counters and results; timeout = 2**CW-1 cycles
// PORTS
//  clk         in   1     system clock, all logic on posedge
//  rst         in   1     synchronous reset, active-high
//  enable      in   1     1 = measure; 0 = idle, results held
//  pwm_in      in   1     PWM under test, asynchronous to clk
//  high_cnt    out  CW    last measured high time, clk cycles
//  period_cnt  out  CW    last measured period (rise to rise), clk cycles
//  meas_valid  out  1     1-cycle pulse when high_cnt/period_cnt update
//  stuck       out  1     sticky: no edge for 2**CW-1 cycles; cleared by next meas_valid
//  stuck_level out  1     synced pwm_in level when stuck was set
//  duty_pct    out  7     [PWM_METER_PCT_EN only] floor(100*high_cnt/period_cnt)
//  pct_valid   out  1     [PWM_METER_PCT_EN only] 1-cycle pulse when duty_pct updates
// BEHAVIOUR
//  - Reset: all outputs 0, sync flops 0, state IDLE, tcnt 0.
//  - pwm_in passes a 2-flop synchronizer, then a delay flop for edge detect.
//    rise = s & ~s_d; fall = ~s & s_d. Pin-to-detect latency is 3 cycles, equal for
//    both edges, so it cancels in the results. Pulses under 1 clk may be lost.
//  - tcnt (CW bits): set to 1 in the cycle after a rise; +1 every cycle otherwise.
//    Saturates at 2**CW-1.
//  - States:
//    IDLE: enable=1 -> ARM
//    ARM: wait for first rise, ignore falls; rise -> HIGH, tcnt<=1
//    HIGH: fall -> latch hcap<=tcnt, go to LOW
//    LOW: rise -> high_cnt<=hcap, period_cnt<=tcnt, meas_valid<=1, stuck<=0,
//         tcnt<=1, go to HIGH
//  - Result registers update in the cycle after the rise; meas_valid is high that one
//    cycle only.
//  - First result needs two rises after enable. Rise at r, fall at f, rise at r2 gives
//    high_cnt = f-r and period_cnt = r2-r.
//  - Timeout: in ARM/HIGH/LOW, if tcnt = 2**CW-1 and no edge this cycle:
//    stuck<=1, stuck_level<=s, state<=ARM, tcnt<=0. Counts continue from ARM entry.
//  - In ARM tcnt increments from 0 so a dead line also times out. The counter is
//    shared; it is not reset on fall.
//  - enable=0 in any state: next state IDLE, no meas_valid; high_cnt/period_cnt/stuck
//    hold. enable=0 wins over a same-cycle edge. Partial measurements are discarded.
//  - rst wins over everything. Reset mid-measurement discards it; outputs return to 0.
// CONFIGURATION
//  PWM_METER_PCT_EN defined:
//  - Sequential restoring divider computes floor(100*high_cnt/period_cnt).
//    Numerator width CW+7.
//  - Starts the cycle after meas_valid; pct_valid pulses exactly CW+8 cycles after
//    meas_valid.
//  - If a new meas_valid arrives while busy, abort and restart on the new values.
//  - period_cnt=0 cannot occur. duty_pct resets to 0 and is held across enable=0.
//  PWM_METER_PCT_EN undefined: divider, duty_pct and pct_valid absent; port list ends
//  at stuck_level.
// TESTING
//  1. rst 2 cycles, enable=1, PWM high 20 / period 101 -> from 2nd rise on,
//     high_cnt=20, period_cnt=101, one meas_valid every 101 cycles.
//  2. CW=8, pwm_in held 0 after enable -> stuck=1, stuck_level=0 after 255 cycles;
//     then a 20/101 PWM -> stuck=0 at the next meas_valid.
//  3. pwm_in held 1 mid-stream (CW=8) -> stuck=1, stuck_level=1; high_cnt/period_cnt
//     keep prior values.
//  4. enable=0 in HIGH, then re-enable -> no meas_valid while low; first new result
//     only after two rises.
//  5. rst mid-LOW -> next cycle all outputs 0; state IDLE, then ARM while enable=1.
//  6. PWM_METER_PCT_EN: 20/101 -> duty_pct=19; 33/99 -> duty_pct=33; pct_valid
//     CW+8 cycles after each meas_valid.

Source files
------------

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures high time and period of an asynchronous PWM input in
// clk cycles, one result per PWM period, and flags a line that stops toggling.
// Optional feature macro: PWM_METER_PCT_EN adds a sequential divider that reports
// duty in whole percent (duty_pct / pct_valid).
module pwm_duty_meter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          pwm_in,
  output logic [CW-1:0] high_cnt,
  output logic [CW-1:0] period_cnt,
  output logic          meas_valid,
  output logic          stuck,
  output logic          stuck_level
`ifdef PWM_METER_PCT_EN
  ,
  output logic [6:0]    duty_pct,
  output logic          pct_valid
`endif
);

  localparam logic [CW-1:0] TMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } state_t;

  state_t        state;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] hcap;

  logic pwm_p0;
  logic pwm_p1;
  logic pwm_p2;
  logic rise;
  logic fall;
  logic timeout;

  // Counter increment that sticks at the all-ones value.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == TMAX) begin
      return v;
    end
    return v + CW'(1);
  endfunction

  // ---- stage p0/p1: two-flop synchronizer; p2: delay flop for edge detect ----
  // Bring pwm_in into the clk domain and keep one extra delayed copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_p0 <= 1'b0;
      pwm_p1 <= 1'b0;
      pwm_p2 <= 1'b0;
    end else begin
      pwm_p0 <= pwm_in;
      pwm_p1 <= pwm_p0;
      pwm_p2 <= pwm_p1;
    end
  end

  assign rise    = pwm_p1 & ~pwm_p2;
  assign fall    = ~pwm_p1 & pwm_p2;
  // A saturated counter with no edge this cycle means the line went quiet.
  assign timeout = (tcnt == TMAX) && !rise && !fall;

  // ---- measurement FSM: counter, captures and registered results ----
  // Track rise/fall/rise and publish high time and period on every second rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        // Disable discards any partial measurement; results and stuck hold.
        state <= IDLE;
        tcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
            tcnt  <= '0;
          end
          ARM: begin
            // Falls are ignored until the first rise anchors a period.
            if (rise) begin
              state <= HIGH;
              tcnt  <= CW'(1);
            end else if (timeout) begin
              stuck       <= 1'b1;
              stuck_level <= pwm_p1;
              tcnt        <= '0;
            end else begin
              tcnt <= sat_inc(tcnt);
            end
          end
          HIGH: begin
            if (fall) begin
              hcap  <= tcnt;
              state <= LOW;
              tcnt  <= sat_inc(tcnt);
            end else if (rise) begin
              // Cannot follow a rise without a fall; restart the period if it does.
              tcnt <= CW'(1);
            end else if (timeout) begin
              stuck       <= 1'b1;
              stuck_level <= pwm_p1;
              state       <= ARM;
              tcnt        <= '0;
            end else begin
              tcnt <= sat_inc(tcnt);
            end
          end
          LOW: begin
            if (rise) begin
              high_cnt   <= hcap;
              period_cnt <= tcnt;
              meas_valid <= 1'b1;
              stuck      <= 1'b0;
              state      <= HIGH;
              tcnt       <= CW'(1);
            end else if (timeout) begin
              stuck       <= 1'b1;
              stuck_level <= pwm_p1;
              state       <= ARM;
              tcnt        <= '0;
            end else begin
              tcnt <= sat_inc(tcnt);
            end
          end
          default: begin
            state <= IDLE;
            tcnt  <= '0;
          end
        endcase
      end
    end
  end

`ifdef PWM_METER_PCT_EN
  localparam int NW = CW + 7;
  localparam int SW = $clog2(NW + 1);

  logic          busy;
  logic [SW-1:0] step;
  logic [NW-1:0] quo;
  logic [CW-1:0] rem;
  logic [CW-1:0] den;
  logic [CW+NW-1:0] div_nxt;

  // 100*h as shifts: 64h + 32h + 4h, widened to the numerator width.
  function automatic logic [NW-1:0] mul100(input logic [CW-1:0] h);
    logic [NW-1:0] hw;
    hw = NW'(h);
    return (hw << 6) + (hw << 5) + (hw << 2);
  endfunction

  // One restoring-division step: returns {remainder, shifted quotient}.
  function automatic logic [CW+NW-1:0] div_step(input logic [CW-1:0] r,
                                                input logic [NW-1:0] q,
                                                input logic [CW-1:0] d);
    logic [CW:0] trial;
    trial = {r, q[NW-1]};
    if (trial >= {1'b0, d}) begin
      return {CW'(trial - {1'b0, d}), q[NW-2:0], 1'b1};
    end
    return {trial[CW-1:0], q[NW-2:0], 1'b0};
  endfunction

  assign div_nxt = div_step(rem, quo, den);

  // ---- divider: load on meas_valid, NW steps, publish on the last step ----
  // A new result while busy restarts the division on the new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      step      <= '0;
      duty_pct  <= '0;
      pct_valid <= 1'b0;
    end else begin
      pct_valid <= 1'b0;
      if (meas_valid) begin
        busy <= 1'b1;
        step <= SW'(NW);
        quo  <= mul100(high_cnt);
        rem  <= '0;
        den  <= period_cnt;
      end else if (busy) begin
        {rem, quo} <= div_nxt;
        step       <= step - SW'(1);
        if (step == SW'(1)) begin
          // high <= period, so the quotient never exceeds 100.
          busy      <= 1'b0;
          pct_valid <= 1'b1;
          duty_pct  <= div_nxt[6:0];
        end
      end
    end
  end
`endif

endmodule
